// File: rtl/mem_pkg.sv
// Shared definitions for the cache-to-memory line arbiter: FSM states,
// default geometry and the requester-id encoding.
package mem_pkg;

    localparam int DEF_WORD_SIZE  = 16;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_LATENCY    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Two-input round-robin picker. The pointer names the requester that wins a
// tie; after every grant it moves to the side that did not win.
module mem_rr_pick
    import mem_pkg::*;
(
    input  logic Clk,
    input  logic Reset_N,
    input  logic grant_en,
    input  logic req_i,
    input  logic req_d,
    output logic pick_vld,
    output logic pick_id
);

    logic ptr_q;

    // Choose the single requester, or the pointer's favourite on a tie
    always_comb begin
        pick_vld = req_i | req_d;
        pick_id  = ptr_q;
        if (req_i && !req_d) begin
            pick_id = REQ_I;
        end else if (req_d && !req_i) begin
            pick_id = REQ_D;
        end
    end

    // Point at the loser of each grant so the other side wins the next tie
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            ptr_q <= REQ_D;
        end else if (grant_en && pick_vld) begin
            ptr_q <= ~pick_id;
        end
    end

endmodule

// File: rtl/mem_line_arbiter.sv
// Serialises whole-line instruction/data miss traffic onto a single
// word-wide memory port: fixed wait, one word per beat, one-cycle ack.
module mem_line_arbiter
    import mem_pkg::*;
#(
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic                            Clk,
    input  logic                            Reset_N,
    input  logic                            i_req,
    input  logic [WORD_SIZE-1:0]            i_addr,
    output logic [WORD_SIZE*LINE_WORDS-1:0] i_line,
    output logic                            i_ack,
    input  logic                            d_req,
    input  logic                            d_we,
    input  logic [WORD_SIZE-1:0]            d_addr,
    input  logic [WORD_SIZE*LINE_WORDS-1:0] d_wline,
    output logic [WORD_SIZE*LINE_WORDS-1:0] d_rline,
    output logic                            d_ack,
    output logic                            m_readM,
    output logic                            m_writeM,
    output logic [WORD_SIZE-1:0]            m_address,
    output logic [WORD_SIZE-1:0]            m_wdata,
    input  logic [WORD_SIZE-1:0]            m_rdata
);

    localparam int LINE_W = WORD_SIZE * LINE_WORDS;
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int CNT_W  = $clog2(max_int(LATENCY, LINE_WORDS));
    localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~WORD_SIZE'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0]     WAIT_LAST  = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0]     XFER_LAST  = CNT_W'(LINE_WORDS - 1);

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 id_q;
    logic                 we_q;
    logic [WORD_SIZE-1:0] base_q;
    logic [LINE_W-1:0]    wline_q;
    logic [WORD_SIZE-1:0] line_buf [LINE_WORDS];
    logic [LINE_W-1:0]    line_next;
    logic [OFF_W-1:0]     beat;
    logic                 in_xfer;
    logic                 pick_vld;
    logic                 pick_id;

    assign beat    = cnt_q[OFF_W-1:0];
    assign in_xfer = (state_q == XFER);

    mem_rr_pick u_pick (
        .Clk      (Clk),
        .Reset_N  (Reset_N),
        .grant_en (state_q == IDLE),
        .req_i    (i_req),
        .req_d    (d_req),
        .pick_vld (pick_vld),
        .pick_id  (pick_id)
    );

    // Assemble the full line including the word arriving on the current beat
    always_comb begin
        line_next = '0;
        for (int w = 0; w < LINE_WORDS; w++) begin
            line_next[w*WORD_SIZE +: WORD_SIZE] = (w == int'(beat)) ? m_rdata : line_buf[w];
        end
    end

    // Transaction FSM: grant, fixed wait, burst, then a single ack cycle
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            id_q    <= REQ_D;
            we_q    <= 1'b0;
            base_q  <= '0;
            i_line  <= '0;
            d_rline <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        state_q <= WAIT;
                        cnt_q   <= '0;
                        id_q    <= pick_id;
                        we_q    <= (pick_id == REQ_D) && d_we;
                        base_q  <= ((pick_id == REQ_D) ? d_addr : i_addr) & ALIGN_MASK;
                    end
                end
                WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        state_q <= XFER;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                XFER: begin
                    if (cnt_q == XFER_LAST) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                        // Publish the line on entry to DONE so it is valid alongside the ack
                        if (!we_q) begin
                            if (id_q == REQ_I) begin
                                i_line <= line_next;
                            end else begin
                                d_rline <= line_next;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Datapath capture: write-back line at grant, read words during the burst
    always_ff @(posedge Clk) begin
        if (state_q == IDLE && pick_vld && pick_id == REQ_D) begin
            wline_q <= d_wline;
        end
        if (in_xfer && !we_q) begin
            line_buf[beat] <= m_rdata;
        end
    end

    assign i_ack     = (state_q == DONE) && (id_q == REQ_I);
    assign d_ack     = (state_q == DONE) && (id_q == REQ_D);
    assign m_readM   = in_xfer && !we_q;
    assign m_writeM  = in_xfer && we_q;
    assign m_address = in_xfer ? (base_q + WORD_SIZE'(beat)) : '0;
    assign m_wdata   = (in_xfer && we_q) ? wline_q[int'(beat)*WORD_SIZE +: WORD_SIZE] : '0;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Scoreboard bench for mem_line_arbiter: stimulus pushes expected bus beats
// and acks, a negedge monitor pops and compares them.
module tb_mem_line_arbiter;

    localparam int WS   = 16;
    localparam int LW   = 4;
    localparam int LAT  = 4;
    localparam int SPAN = LAT + LW + 2;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
    } beat_t;

    typedef struct {
        int          cyc;
        logic [63:0] line;
        logic [63:0] other;
    } ack_t;

    logic        Clk = 1'b0;
    logic        Reset_N;
    logic        i_req;
    logic [15:0] i_addr;
    logic [63:0] i_line;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [63:0] d_wline;
    logic [63:0] d_rline;
    logic        d_ack;
    logic        m_readM;
    logic        m_writeM;
    logic [15:0] m_address;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int t0;

    beat_t exp_beats[$];
    ack_t  exp_i[$];
    ack_t  exp_d[$];
    logic [63:0] model_i;
    logic [63:0] model_d;

    mem_line_arbiter #(.WORD_SIZE(WS), .LINE_WORDS(LW), .LATENCY(LAT)) dut (
        .Clk       (Clk),
        .Reset_N   (Reset_N),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_line    (i_line),
        .i_ack     (i_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wline   (d_wline),
        .d_rline   (d_rline),
        .d_ack     (d_ack),
        .m_readM   (m_readM),
        .m_writeM  (m_writeM),
        .m_address (m_address),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata)
    );

    // Memory model: each word holds its own address plus 0x100
    assign m_rdata = m_address + 16'h0100;

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail1(input string name, input logic [63:0] act);
        n_checks++;
        $display("FAIL %s: got %h expected nothing (cycle %0d)", name, act, cyc);
    endtask

    function automatic logic [63:0] rd_line(input logic [15:0] base);
        logic [63:0] l;
        for (int k = 0; k < LW; k++) l[k*WS +: WS] = base + 16'(k) + 16'h0100;
        return l;
    endfunction

    task automatic push_read(input bit side_d, input logic [15:0] addr, input int tg);
        logic [15:0] base;
        ack_t a;
        base = addr & 16'hFFFC;
        for (int k = 0; k < LW; k++)
            exp_beats.push_back('{tg + LAT + 1 + k, base + 16'(k), 1'b0, 16'h0});
        a.cyc  = tg + LAT + LW + 1;
        a.line = rd_line(base);
        if (side_d) begin
            model_d = a.line;
            a.other = model_i;
            exp_d.push_back(a);
        end else begin
            model_i = a.line;
            a.other = model_d;
            exp_i.push_back(a);
        end
    endtask

    task automatic push_write(input logic [15:0] addr, input logic [63:0] wl, input int tg);
        logic [15:0] base;
        ack_t a;
        base = addr & 16'hFFFC;
        for (int k = 0; k < LW; k++)
            exp_beats.push_back('{tg + LAT + 1 + k, base + 16'(k), 1'b1, wl[k*WS +: WS]});
        a.cyc   = tg + LAT + LW + 1;
        a.line  = model_d;
        a.other = model_i;
        exp_d.push_back(a);
    endtask

    task automatic wait_ack(input bit side_d, input bit drop);
        bit seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge Clk);
            seen = side_d ? d_ack : i_ack;
        end
        if (!seen) fail1(side_d ? "d_ack_timeout" : "i_ack_timeout", 64'(cyc));
        @(posedge Clk);
        #1;
        if (drop) begin
            if (side_d) d_req = 1'b0;
            else        i_req = 1'b0;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_acks"}, {62'd0, i_ack, d_ack}, 64'd0);
        chk({tag, "_strobes"}, {62'd0, m_readM, m_writeM}, 64'd0);
        chk({tag, "_bus"}, {32'd0, m_address, m_wdata}, 64'd0);
        chk({tag, "_i_line"}, i_line, 64'd0);
        chk({tag, "_d_rline"}, d_rline, 64'd0);
    endtask

    task automatic clear_expect();
        exp_beats.delete();
        exp_i.delete();
        exp_d.delete();
        model_i = '0;
        model_d = '0;
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #1;
        Reset_N = 1'b0;
        i_req   = 1'b0;
        d_req   = 1'b0;
        #1;
        check_zero("reset");
        clear_expect();
        repeat (2) @(posedge Clk);
        #1;
        Reset_N = 1'b1;
    endtask

    // Monitor: compare every bus beat and ack against the scoreboard
    always @(negedge Clk) begin
        beat_t b;
        ack_t  a;
        if (m_readM || m_writeM) begin
            if (exp_beats.size() == 0) begin
                fail1("unexpected_beat", {16'(cyc), m_address, 14'd0, m_readM, m_writeM, m_wdata});
            end else begin
                b = exp_beats.pop_front();
                chk("beat", {16'(cyc), m_address, 14'd0, m_readM, m_writeM, m_wdata},
                            {16'(b.cyc), b.addr, 14'd0, ~b.we, b.we, b.wdata});
            end
        end else begin
            chk("bus_idle", {32'd0, m_address, m_wdata}, 64'd0);
        end
        if (i_ack) begin
            if (exp_i.size() == 0) fail1("unexpected_i_ack", 64'(cyc));
            else begin
                a = exp_i.pop_front();
                chk("i_ack_cycle", 64'(cyc), 64'(a.cyc));
                chk("i_line", i_line, a.line);
                chk("d_rline_hold", d_rline, a.other);
                chk("i_ack_excl", {63'd0, d_ack}, 64'd0);
            end
        end
        if (d_ack) begin
            if (exp_d.size() == 0) fail1("unexpected_d_ack", 64'(cyc));
            else begin
                a = exp_d.pop_front();
                chk("d_ack_cycle", 64'(cyc), 64'(a.cyc));
                chk("d_rline", d_rline, a.line);
                chk("i_line_hold", i_line, a.other);
            end
        end
    end

    initial begin
        Reset_N = 1'b0;
        i_req   = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        i_addr  = '0;
        d_addr  = '0;
        d_wline = '0;
        clear_expect();
        repeat (2) @(posedge Clk);
        #1;
        check_zero("por");
        Reset_N = 1'b1;

        // Single instruction read
        @(posedge Clk); #1;
        t0 = cyc; i_addr = 16'h0013; i_req = 1'b1;
        push_read(1'b0, 16'h0013, t0);
        wait_ack(1'b0, 1'b1);

        // Data write-back leaves d_rline alone
        @(posedge Clk); #1;
        t0 = cyc; d_we = 1'b1; d_addr = 16'h0040;
        d_wline = 64'hDDDD_CCCC_BBBB_AAAA; d_req = 1'b1;
        push_write(16'h0040, 64'hDDDD_CCCC_BBBB_AAAA, t0);
        wait_ack(1'b1, 1'b1);
        d_we = 1'b0;

        // Simultaneous pair right after reset: data first
        do_reset();
        @(posedge Clk); #1;
        t0 = cyc; i_addr = 16'h0100; d_addr = 16'h0200; i_req = 1'b1; d_req = 1'b1;
        push_read(1'b1, 16'h0200, t0);
        push_read(1'b0, 16'h0100, t0 + SPAN);
        wait_ack(1'b1, 1'b1);
        wait_ack(1'b0, 1'b1);

        // Lone data grant moves the pointer to instruction
        @(posedge Clk); #1;
        t0 = cyc; d_addr = 16'h0301; d_req = 1'b1;
        push_read(1'b1, 16'h0301, t0);
        wait_ack(1'b1, 1'b1);

        // Next simultaneous pair: instruction first
        @(posedge Clk); #1;
        t0 = cyc; i_addr = 16'h0402; d_addr = 16'h0503; i_req = 1'b1; d_req = 1'b1;
        push_read(1'b0, 16'h0402, t0);
        push_read(1'b1, 16'h0503, t0 + SPAN);
        wait_ack(1'b0, 1'b1);
        wait_ack(1'b1, 1'b1);

        // Request withdrawn at cycle 3 still completes, no second burst
        @(posedge Clk); #1;
        t0 = cyc; i_addr = 16'h0620; i_req = 1'b1;
        push_read(1'b0, 16'h0620, t0);
        repeat (3) @(posedge Clk);
        #1; i_req = 1'b0;
        wait_ack(1'b0, 1'b0);
        repeat (15) @(posedge Clk);
        #1;
        chk("no_rerun", 64'(exp_beats.size() + exp_i.size()), 64'd0);

        // Reset in the middle of a burst abandons the transaction
        t0 = cyc; d_addr = 16'h0080; d_req = 1'b1;
        exp_beats.push_back('{t0 + LAT + 1, 16'h0080, 1'b0, 16'h0});
        repeat (6) @(posedge Clk);
        #1;
        Reset_N = 1'b0;
        d_req   = 1'b0;
        #1;
        check_zero("mid_reset");
        clear_expect();
        @(posedge Clk); #1;
        Reset_N = 1'b1;
        @(posedge Clk); #1;
        t0 = cyc; d_addr = 16'h0084; d_req = 1'b1;
        push_read(1'b1, 16'h0084, t0);
        wait_ack(1'b1, 1'b1);

        // Top-of-memory line: addresses stay inside the line
        @(posedge Clk); #1;
        t0 = cyc; d_addr = 16'hFFFE; d_req = 1'b1;
        push_read(1'b1, 16'hFFFE, t0);
        wait_ack(1'b1, 1'b1);

        repeat (12) @(posedge Clk);
        #1;
        chk("drained", 64'(exp_beats.size() + exp_i.size() + exp_d.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
